seq_alu: RTL

- Multi-cycle successor to the datapath ALU.
- Keeps the single-cycle logic and arithmetic operation set, adding signed/unsigned compare, XOR and iterative unsigned multiply/divide (RV64M-style MUL/MULHU/DIVU/REMU).
- Operands are accepted and results returned through valid/ready handshakes, so the execute stage can stall on long operations.
- Sits between the ALU control decode and the EX/MEM pipeline register.

---
 rtl/seq_alu.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with valid/ready handshakes and iterative MUL/DIV
//
// Purpose: logic/arith/compare ops complete one cycle after acceptance. MUL/MULHU use radix-2
// shift-add and DIVU/REMU use restoring division. Both produce one bit per cycle and have a
// fixed latency of data_length+1.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        request handshake (alu_operation, alu_in1, alu_in2)
//   out_valid/out_ready      result handshake (alu_result, zero, illegal_op)
module seq_alu #(
  parameter int data_length = 64,
  parameter int CNT_W       = $clog2(data_length) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             alu_operation,
  input  logic [data_length-1:0] alu_in1,
  input  logic [data_length-1:0] alu_in2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [data_length-1:0] alu_result,
  output logic                   zero,
  output logic                   illegal_op
);

  localparam int W = data_length;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [W-1:0]     b_q, b_d;           // multiplicand or divisor
  logic [2*W-1:0]   acc_q, acc_d;       // mul: {product_hi, multiplier}; div: {remainder, quotient}
  logic [W-1:0]     result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  // Result of ops that finish at acceptance, including divide-by-zero.
  logic [W-1:0] quick_res;
  logic         quick_ill;

  always_comb begin
    quick_res = '0;
    quick_ill = 1'b0;
    case (alu_operation)
      OP_AND:   quick_res = alu_in1 & alu_in2;
      OP_OR:    quick_res = alu_in1 | alu_in2;
      OP_ADD:   quick_res = alu_in1 + alu_in2;
      OP_SUB:   quick_res = alu_in1 - alu_in2;
      OP_XOR:   quick_res = alu_in1 ^ alu_in2;
      OP_NOR:   quick_res = ~(alu_in1 | alu_in2);
      OP_SLT:   quick_res = {{(W-1){1'b0}}, ($signed(alu_in1) < $signed(alu_in2))};
      OP_SLTU:  quick_res = {{(W-1){1'b0}}, (alu_in1 < alu_in2)};
      OP_DIVU:  quick_res = '1;
      OP_REMU:  quick_res = alu_in1;
      OP_MUL, OP_MULHU: quick_res = '0;
      default:  quick_ill = 1'b1;
    endcase
  end

  // One iteration step of the multiplier and of the divider.
  logic [W:0]     mul_sum;
  logic [W:0]     rem_shift;
  logic [W:0]     trial;
  logic [2*W-1:0] acc_step;
  logic           is_div_q;

  assign is_div_q = (op_q == OP_DIVU) || (op_q == OP_REMU);

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? b_q : {W{1'b0}})};
    rem_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    trial     = rem_shift - {1'b0, b_q};
    if (is_div_q) begin
      // Non-negative trial means the divisor fits: keep difference, shift in quotient bit 1.
      if (!trial[W]) acc_step = {trial[W-1:0], acc_q[W-2:0], 1'b1};
      else           acc_step = {rem_shift[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[W-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    b_d       = b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = alu_operation;
          b_d  = alu_in2;
          if ((alu_operation == OP_MUL) || (alu_operation == OP_MULHU) ||
              (((alu_operation == OP_DIVU) || (alu_operation == OP_REMU)) && (alu_in2 != '0))) begin
            acc_d   = {{W{1'b0}}, alu_in1};
            cnt_d   = CNT_W'(W);
            state_d = BUSY;
          end else begin
            result_d  = quick_res;
            illegal_d = quick_ill;
            state_d   = DONE;
          end
        end
      end
      BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        // Last iteration registers the selected half directly from the stepped accumulator.
        if (cnt_q == CNT_W'(1)) begin
          illegal_d = 1'b0;
          state_d   = DONE;
          if ((op_q == OP_MULHU) || (op_q == OP_REMU)) result_d = acc_step[2*W-1:W];
          else                                         result_d = acc_step[W-1:0];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign alu_result = result_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;

endmodule
